// File: rtl/sdp_split_stim_gen.sv
// sdp_split_stim_gen: self-checking traffic generator for one split half of a
// simple-dual-port block RAM. It fills the RAM with an LFSR pattern, patches one
// byte lane per word with the inverted pattern, then reads every word back and
// compares it with a regenerated expected value.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          one-cycle pulse that begins a run (accepted in IDLE/DONE only)
//   wa, wd, we, be write port of the RAM half under test
//   ra, re, rd     read port; rd is valid one cycle after re
//   busy           high while a run is in progress
//   done, pass     run finished / finished without mismatches
//   err_count      saturating count of mismatched words
//   fail_addr      address of the first mismatch (0 if none)
module sdp_split_stim_gen #(
    parameter int unsigned ABITS     = 10,
    parameter int unsigned DBITS     = 36,
    parameter int unsigned NBYTES    = 4,
    parameter int unsigned BYTEWIDTH = 9,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ABITS-1:0]  wa,
    output logic [DBITS-1:0]  wd,
    output logic              we,
    output logic [NBYTES-1:0] be,
    output logic [ABITS-1:0]  ra,
    output logic              re,
    input  logic [DBITS-1:0]  rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ABITS-1:0]  fail_addr
);

    localparam logic [31:0]    TAPS = 32'h8020_0003;
    // Counter value reached after the last address of a pass has been issued.
    localparam logic [ABITS:0] LAST = {1'b1, {ABITS{1'b0}}};

    typedef enum logic [2:0] {StIdle, StFill, StPatch, StRead, StDrain, StDone} state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [DBITS-1:0] pattern(input logic [31:0] l);
        return DBITS'({l, l});
    endfunction

    // One-hot byte enable selecting lane (a mod NBYTES).
    function automatic logic [NBYTES-1:0] lane_onehot(input logic [ABITS:0] a);
        logic [NBYTES-1:0] o;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            o[k] = ((32'(a) % NBYTES) == k);
        end
        return o;
    endfunction

    function automatic logic [DBITS-1:0] lane_mask(input logic [NBYTES-1:0] b);
        logic [DBITS-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            m[k*BYTEWIDTH +: BYTEWIDTH] = {BYTEWIDTH{b[k]}};
        end
        return m;
    endfunction

    state_e            state_q, state_d;
    logic [ABITS:0]    cnt_q, cnt_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [1:0]        sync_q;
    logic [ABITS-1:0]  wa_q, wa_d, ra_q, ra_d;
    logic [DBITS-1:0]  wd_q, wd_d;
    logic              we_q, we_d, re_q, re_d;
    logic [NBYTES-1:0] be_q, be_d;
    logic [DBITS-1:0]  exp_q, exp_d, exp_p_q, exp_p_d;
    logic              chk_q, chk_d;
    logic [ABITS-1:0]  addr_p_q, addr_p_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [ABITS-1:0]  fail_q, fail_d;

    // Address and LFSR value for the word issued this cycle; a wrapped counter
    // starts the next pass at address 0 with a freshly seeded LFSR.
    logic              wrap;
    logic [ABITS:0]    cur_a;
    logic [31:0]       cur_l;
    logic [DBITS-1:0]  cur_p;

    always_comb begin
        wrap  = (cnt_q == LAST);
        cur_a = wrap ? '0 : cnt_q;
        cur_l = wrap ? SEED : lfsr_q;
        cur_p = pattern(cur_l);

        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        we_d     = 1'b0;
        be_d     = be_q;
        ra_d     = ra_q;
        re_d     = 1'b0;
        exp_d    = exp_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;

        // Read pipeline: expected word and address follow re by one cycle so
        // they line up with rd.
        chk_d    = re_q;
        exp_p_d  = exp_q;
        addr_p_d = ra_q;

        if (chk_q && (rd != exp_p_q)) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                fail_d = addr_p_q;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                // Second sync flop gates the first run after reset release.
                if (start && sync_q[1]) begin
                    state_d = StFill;
                    err_d   = '0;
                    fail_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    wa_d    = '0;
                    wd_d    = pattern(SEED);
                    be_d    = '1;
                    lfsr_d  = lfsr_step(SEED);
                    cnt_d   = {{ABITS{1'b0}}, 1'b1};
                end
            end
            StFill: begin
                we_d   = 1'b1;
                wa_d   = cur_a[ABITS-1:0];
                lfsr_d = lfsr_step(cur_l);
                cnt_d  = cur_a + 1'b1;
                if (wrap) begin
                    state_d = StPatch;
                    wd_d    = ~cur_p;
                    be_d    = lane_onehot(cur_a);
                end else begin
                    wd_d = cur_p;
                    be_d = '1;
                end
            end
            StPatch: begin
                lfsr_d = lfsr_step(cur_l);
                cnt_d  = cur_a + 1'b1;
                if (wrap) begin
                    state_d = StRead;
                    re_d    = 1'b1;
                    ra_d    = '0;
                    exp_d   = cur_p ^ lane_mask(lane_onehot(cur_a));
                end else begin
                    we_d = 1'b1;
                    wa_d = cur_a[ABITS-1:0];
                    wd_d = ~cur_p;
                    be_d = lane_onehot(cur_a);
                end
            end
            StRead: begin
                if (wrap) begin
                    state_d = StDrain;
                end else begin
                    re_d   = 1'b1;
                    ra_d   = cur_a[ABITS-1:0];
                    exp_d  = cur_p ^ lane_mask(lane_onehot(cur_a));
                    lfsr_d = lfsr_step(cur_l);
                    cnt_d  = cur_a + 1'b1;
                end
            end
            StDrain: begin
                state_d = StDone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == 16'd0);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lfsr_q   <= '0;
            sync_q   <= '0;
            wa_q     <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            ra_q     <= '0;
            re_q     <= 1'b0;
            exp_q    <= '0;
            chk_q    <= 1'b0;
            exp_p_q  <= '0;
            addr_p_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            sync_q   <= {sync_q[0], 1'b1};
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            be_q     <= be_d;
            ra_q     <= ra_d;
            re_q     <= re_d;
            exp_q    <= exp_d;
            chk_q    <= chk_d;
            exp_p_q  <= exp_p_d;
            addr_p_q <= addr_p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign wa        = wa_q;
    assign wd        = wd_q;
    assign we        = we_q;
    assign be        = be_q;
    assign ra        = ra_q;
    assign re        = re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_q;

endmodule

// File: tb/tb_sdp_split_stim_gen.sv
// Bench for sdp_split_stim_gen with ABITS=4 (16 words) against a small RAM
// model that can corrupt one word or ignore byte enables.
module tb_sdp_split_stim_gen;

    localparam int ABITS  = 4;
    localparam int DBITS  = 36;
    localparam int NBYTES = 4;
    localparam int BW     = 9;
    localparam int N      = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ABITS-1:0]  wa, ra, fail_addr;
    logic [DBITS-1:0]  wd;
    logic [DBITS-1:0]  rd = '0;
    logic              we, re, busy, done, pass;
    logic [NBYTES-1:0] be;
    logic [15:0]       err_count;

    int n_checks = 0;
    int n_errors = 0;
    bit corrupt  = 1'b0;
    bit drop_be  = 1'b0;

    logic [DBITS-1:0] mem [N];

    always #5 clk = ~clk;

    sdp_split_stim_gen #(
        .ABITS     (ABITS),
        .DBITS     (DBITS),
        .NBYTES    (NBYTES),
        .BYTEWIDTH (BW),
        .SEED      (32'hACE1_2468)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wa        (wa),
        .wd        (wd),
        .we        (we),
        .be        (be),
        .ra        (ra),
        .re        (re),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    // RAM model: byte-masked write, registered read, optional faults.
    always @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (be[k] || drop_be) mem[wa][k*BW +: BW] <= wd[k*BW +: BW];
            end
        end
        if (re) rd <= mem[ra] ^ ((corrupt && ra == 4'd5) ? 36'd1 : 36'd0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full run: start sampled at the edge ending cycle 0; cycle c is sampled
    // at the falling edge after the c-th following rising edge.
    task automatic run_test(input string tag, input int repulse, input int exp_err,
                            input int exp_fail, input bit exp_pass);
        int we_first, we_last, we_n, re_first, re_last, re_n;
        int busy_first, busy_last, overlap;
        we_first = -1; we_last = -1; we_n = 0;
        re_first = -1; re_last = -1; re_n = 0;
        busy_first = -1; busy_last = -1; overlap = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 3*N + 3; c++) begin
            @(negedge clk);
            start = (c == repulse);
            if (we) begin
                if (we_first < 0) we_first = c;
                we_last = c; we_n++;
            end
            if (re) begin
                if (re_first < 0) re_first = c;
                re_last = c; re_n++;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (we && re) overlap++;
            if (c == 1) begin
                check_eq({tag, " done clr"}, done, 0);
                check_eq({tag, " err clr"}, err_count, 0);
                check_eq({tag, " wd0"}, wd, 36'h8_ACE1_2468);
                check_eq({tag, " be0"}, be, 4'hF);
            end
            if (c == 2) check_eq({tag, " wd1"}, wd, 36'h4_5670_9234);
            if (c == N) check_eq({tag, " wa last"}, wa, N - 1);
            if (c == N + 1) begin
                check_eq({tag, " patch wd0"}, wd, 36'h7_531E_DB97);
                check_eq({tag, " patch be0"}, be, 4'b0001);
            end
            if (c == N + 2) check_eq({tag, " patch be1"}, be, 4'b0010);
            if (c == 3*N) check_eq({tag, " ra last"}, ra, N - 1);
            if (c == 3*N + 1) check_eq({tag, " done early"}, done, 0);
            if (c == 3*N + 2) begin
                check_eq({tag, " done"}, done, 1);
                check_eq({tag, " pass"}, pass, exp_pass);
                check_eq({tag, " err"}, err_count, exp_err);
                check_eq({tag, " fail_addr"}, fail_addr, exp_fail);
            end
        end
        check_eq({tag, " we first"}, we_first, 1);
        check_eq({tag, " we last"}, we_last, 2*N);
        check_eq({tag, " we count"}, we_n, 2*N);
        check_eq({tag, " re first"}, re_first, 2*N + 1);
        check_eq({tag, " re last"}, re_last, 3*N);
        check_eq({tag, " re count"}, re_n, N);
        check_eq({tag, " busy first"}, busy_first, 1);
        check_eq({tag, " busy last"}, busy_last, 3*N + 1);
        check_eq({tag, " we&re"}, overlap, 0);
        check_eq({tag, " done held"}, done, 1);
    endtask

    initial begin
        int act;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset ctl", {we, re, busy, done, pass, err_count, fail_addr, wa, ra, be}, 0);
        check_eq("reset wd", wd, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_test("clean", -1, 0, 0, 1'b1);

        corrupt = 1'b1;
        run_test("corrupt5", -1, 1, 5, 1'b0);
        corrupt = 1'b0;

        // Starts from DONE with err_count=1; cycle-1 checks cover the clear.
        run_test("b2b", -1, 0, 0, 1'b1);

        drop_be = 1'b1;
        run_test("drop_be", -1, N, 0, 1'b0);
        drop_be = 1'b0;

        run_test("repulse", 10, 0, 0, 1'b1);

        // Reset asserted mid-run in cycle 20.
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst ctl", {we, re, busy, done, pass, err_count, fail_addr, wa, ra, be}, 0);
        check_eq("midrst wd", wd, 0);
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if (we || re || busy) act++;
        end
        check_eq("midrst quiet", act, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_test("after rst", -1, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
